// File: rtl/vga_pkg.sv
// VGA timing constants and the sprite position record used by the sprite layer.
package vga_pkg;

  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int SWAP_LINE = 480;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vis;
  } sprite_pos_t;

endpackage

// File: rtl/sprite_pos_bank.sv
// Double-buffered sprite positions: game logic writes the shadow bank and
// a swap strobe copies every shadow entry into the active bank at once.
module sprite_pos_bank
  import vga_pkg::*;
#(
  parameter int NUM_SPRITES = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [1:0]                      wr_idx,
  input  sprite_pos_t                     wr_data,
  input  logic                            swap,
  output sprite_pos_t [NUM_SPRITES-1:0]   active
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_entry
      sprite_pos_t shadow_reg;
      sprite_pos_t active_reg;

      // The swap reads the pre-write shadow, so a coincident write waits a frame.
      always_ff @(posedge clk) begin
        if (reset) begin
          shadow_reg <= '0;
          active_reg <= '0;
        end else begin
          if (wr_en && (int'(wr_idx) == gi)) begin
            shadow_reg <= wr_data;
          end
          if (swap) begin
            active_reg <= shadow_reg;
          end
        end
      end

      assign active[gi] = active_reg;
    end
  endgenerate

endmodule

// File: rtl/sprite_layer_arbiter.sv
// Per-pixel sprite scheduler feeding VGA_LOGIC: box test, priority pick, shared ROM fetch.
// Optional aim/shot detector is built when SPRITE_HIT_DETECT_EN is defined.
module sprite_layer_arbiter
  import vga_pkg::*;
#(
  parameter int         NUM_SPRITES = 4,
  parameter int         SPR_W       = 32,
  parameter int         SPR_H       = 32,
  parameter logic [5:0] KEY_COLOR   = 6'b110011,
  parameter int         LOOKAHEAD   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hor_count,
  input  logic [9:0]  ver_count,
  input  logic        pos_wr_en,
  input  logic [1:0]  pos_wr_idx,
  input  logic [9:0]  pos_wr_x,
  input  logic [9:0]  pos_wr_y,
  input  logic        pos_wr_vis,
  output logic [11:0] rom_addr,
  input  logic [5:0]  rom_data,
  output logic        draw,
  output logic [5:0]  rgb_out,
`ifdef SPRITE_HIT_DETECT_EN
  input  logic        fire,
  input  logic [9:0]  aim_x,
  input  logic [9:0]  aim_y,
  output logic        hit_valid,
  output logic [1:0]  hit_idx,
  output logic        hit_miss,
`endif
  output logic        frame_tick
);

  logic [10:0] h_sum;
  logic        h_wrap;
  logic [9:0]  h_ahead;
  logic [9:0]  v_ahead;
  logic        in_active;
  logic        swap;

  // Look ahead by the pipeline depth so the result lands on the displayed pixel.
  assign h_sum   = {1'b0, hor_count} + 11'(LOOKAHEAD);
  assign h_wrap  = h_sum >= 11'(H_TOTAL);
  assign h_ahead = h_wrap ? 10'(h_sum - 11'(H_TOTAL)) : h_sum[9:0];

  always_comb begin
    v_ahead = ver_count;
    if (h_wrap) begin
      v_ahead = (ver_count == 10'(V_TOTAL - 1)) ? 10'd0 : ver_count + 10'd1;
    end
  end

  assign in_active = (h_ahead < 10'(H_ACTIVE)) && (v_ahead < 10'(V_ACTIVE));
  assign swap      = (hor_count == 10'd0) && (ver_count == 10'(SWAP_LINE));

  sprite_pos_t                   wr_data;
  sprite_pos_t [NUM_SPRITES-1:0] active;

  assign wr_data = {pos_wr_x, pos_wr_y, pos_wr_vis};

  sprite_pos_bank #(
    .NUM_SPRITES(NUM_SPRITES)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (pos_wr_en),
    .wr_idx (pos_wr_idx),
    .wr_data(wr_data),
    .swap   (swap),
    .active (active)
  );

  logic [NUM_SPRITES-1:0] hit_vec;

  // Box bounds are widened to 11 bits so sprites near x/y=1023 do not wrap.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_box
      logic [10:0] x_lo;
      logic [10:0] x_hi;
      logic [10:0] y_lo;
      logic [10:0] y_hi;

      assign x_lo = {1'b0, active[gi].x};
      assign y_lo = {1'b0, active[gi].y};
      assign x_hi = x_lo + 11'(SPR_W);
      assign y_hi = y_lo + 11'(SPR_H);

      assign hit_vec[gi] = active[gi].vis && in_active
                         && ({1'b0, h_ahead} >= x_lo) && ({1'b0, h_ahead} < x_hi)
                         && ({1'b0, v_ahead} >= y_lo) && ({1'b0, v_ahead} < y_hi);
    end
  endgenerate

  logic       win_hit;
  logic [1:0] win_idx;
  logic [4:0] win_row;
  logic [4:0] win_col;

  always_comb begin
    win_hit = 1'b0;
    win_idx = 2'd0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        win_hit = 1'b1;
        win_idx = 2'(i);
      end
    end
  end

  assign win_row = 5'(v_ahead - active[win_idx].y);
  assign win_col = 5'(h_ahead - active[win_idx].x);

  logic s1_hit_reg;
  logic s2_hit_reg;
  logic opaque;

  assign opaque = s2_hit_reg && (rom_data != KEY_COLOR);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_hit_reg <= 1'b0;
      s2_hit_reg <= 1'b0;
      rom_addr   <= 12'd0;
      draw       <= 1'b0;
      rgb_out    <= 6'd0;
      frame_tick <= 1'b0;
    end else begin
      s1_hit_reg <= win_hit;
      if (win_hit) begin
        rom_addr <= {win_idx, win_row, win_col};
      end
      s2_hit_reg <= s1_hit_reg;
      draw       <= opaque;
      rgb_out    <= opaque ? rom_data : 6'd0;
      frame_tick <= swap;
    end
  end

`ifdef SPRITE_HIT_DETECT_EN
  localparam logic [1:0] DET_IDLE = 2'd0;
  localparam logic [1:0] DET_WAIT = 2'd1;
  localparam logic [1:0] DET_REC  = 2'd2;

  logic [1:0] s1_idx_reg;
  logic [1:0] s2_idx_reg;
  logic [1:0] s3_idx_reg;
  logic [1:0] det_state_reg;
  logic [9:0] aim_x_reg;
  logic [9:0] aim_y_reg;
  logic       found_reg;
  logic [1:0] found_idx_reg;
  logic       aim_match;

  // The stage-3 index travels alongside draw, so it names the sprite on screen now.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_idx_reg <= 2'd0;
      s2_idx_reg <= 2'd0;
      s3_idx_reg <= 2'd0;
    end else begin
      s1_idx_reg <= win_idx;
      s2_idx_reg <= s1_idx_reg;
      s3_idx_reg <= s2_idx_reg;
    end
  end

  assign aim_match = draw && (hor_count == aim_x_reg) && (ver_count == aim_y_reg);

  // Armed shots wait for a frame start, record over that full frame, report at the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      det_state_reg <= DET_IDLE;
      aim_x_reg     <= 10'd0;
      aim_y_reg     <= 10'd0;
      found_reg     <= 1'b0;
      found_idx_reg <= 2'd0;
      hit_valid     <= 1'b0;
      hit_idx       <= 2'd0;
      hit_miss      <= 1'b0;
    end else begin
      hit_valid <= 1'b0;
      case (det_state_reg)
        DET_IDLE: begin
          if (fire) begin
            aim_x_reg     <= aim_x;
            aim_y_reg     <= aim_y;
            found_reg     <= 1'b0;
            found_idx_reg <= 2'd0;
            det_state_reg <= DET_WAIT;
          end
        end
        DET_WAIT: begin
          if (swap) begin
            det_state_reg <= DET_REC;
          end
        end
        DET_REC: begin
          if (swap) begin
            hit_valid     <= 1'b1;
            hit_idx       <= found_reg ? found_idx_reg : 2'd0;
            hit_miss      <= !found_reg;
            det_state_reg <= DET_IDLE;
          end else if (aim_match && !found_reg) begin
            found_reg     <= 1'b1;
            found_idx_reg <= s3_idx_reg;
          end
        end
        default: det_state_reg <= DET_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
// Directed bench for sprite_layer_arbiter: table of pixel probes plus swap/reset sequences.
module tb_sprite_layer_arbiter;

  localparam logic [5:0] KEY = 6'b110011;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hor_count;
  logic [9:0]  ver_count;
  logic        pos_wr_en;
  logic [1:0]  pos_wr_idx;
  logic [9:0]  pos_wr_x;
  logic [9:0]  pos_wr_y;
  logic        pos_wr_vis;
  logic [11:0] rom_addr;
  logic [5:0]  rom_data;
  logic        draw;
  logic [5:0]  rgb_out;
  logic        frame_tick;
`ifdef SPRITE_HIT_DETECT_EN
  logic        fire;
  logic [9:0]  aim_x;
  logic [9:0]  aim_y;
  logic        hit_valid;
  logic [1:0]  hit_idx;
  logic        hit_miss;
`endif

  int total = 0;
  int bad   = 0;
  bit key_mode = 1'b0;

  always #5 clk = ~clk;

  sprite_layer_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .hor_count (hor_count),
    .ver_count (ver_count),
    .pos_wr_en (pos_wr_en),
    .pos_wr_idx(pos_wr_idx),
    .pos_wr_x  (pos_wr_x),
    .pos_wr_y  (pos_wr_y),
    .pos_wr_vis(pos_wr_vis),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .draw      (draw),
    .rgb_out   (rgb_out),
`ifdef SPRITE_HIT_DETECT_EN
    .fire      (fire),
    .aim_x     (aim_x),
    .aim_y     (aim_y),
    .hit_valid (hit_valid),
    .hit_idx   (hit_idx),
    .hit_miss  (hit_miss),
`endif
    .frame_tick(frame_tick)
  );

  // Sprite ROM model: one flat colour per sprite; sprite 0 right half keyed in key_mode.
  function automatic logic [5:0] rom_fn(input logic [11:0] a);
    logic [1:0] idx;
    logic [4:0] col;
    idx = a[11:10];
    col = a[4:0];
    case (idx)
      2'd0:    rom_fn = (key_mode && col >= 5'd16) ? KEY : 6'h0C;
      2'd1:    rom_fn = 6'h15;
      2'd2:    rom_fn = 6'h2A;
      default: rom_fn = 6'h07;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic neutral();
    hor_count = 10'd700;
    ver_count = 10'd100;
  endtask

  // Drive one counter pair, sample rom_addr after stage 1 and draw/rgb after stage 3.
  task automatic probe(input int h, input int v, output logic [11:0] addr,
                       output logic d, output logic [5:0] rgb);
    @(negedge clk);
    hor_count = 10'(h);
    ver_count = 10'(v);
    @(negedge clk);
    addr = rom_addr;
    neutral();
    @(negedge clk);
    @(negedge clk);
    d   = draw;
    rgb = rgb_out;
  endtask

  task automatic probe_draw(input string name, input int h, input int v, input logic exp_d);
    logic [11:0] a;
    logic        d;
    logic [5:0]  c;
    probe(h, v, a, d, c);
    $display("probe %s h=%0d v=%0d draw=%0b rgb=%0h", name, h, v, d, c);
    check(name, 32'(d), 32'(exp_d));
  endtask

  task automatic wr_pos(input int idx, input int x, input int y, input logic vis);
    @(negedge clk);
    pos_wr_en  = 1'b1;
    pos_wr_idx = 2'(idx);
    pos_wr_x   = 10'(x);
    pos_wr_y   = 10'(y);
    pos_wr_vis = vis;
    @(negedge clk);
    pos_wr_en  = 1'b0;
  endtask

  task automatic do_swap(input string name);
    @(negedge clk);
    hor_count = 10'd0;
    ver_count = 10'd480;
    @(negedge clk);
    neutral();
    $display("swap %s frame_tick=%0b", name, frame_tick);
    check(name, 32'(frame_tick), 32'd1);
  endtask

  task automatic load_setup(input int s);
    case (s)
      0: begin
        key_mode = 1'b0;
        wr_pos(0, 100, 50, 1'b1);
        wr_pos(1, 0, 0, 1'b0);
        wr_pos(2, 0, 0, 1'b0);
        wr_pos(3, 0, 0, 1'b0);
      end
      1: begin
        key_mode = 1'b1;
        wr_pos(0, 200, 200, 1'b1);
        wr_pos(1, 200, 200, 1'b1);
        wr_pos(2, 300, 300, 1'b1);
        wr_pos(3, 0, 0, 1'b0);
      end
      default: begin
        key_mode = 1'b0;
        wr_pos(0, 0, 0, 1'b0);
        wr_pos(1, 0, 0, 1'b0);
        wr_pos(2, 0, 470, 1'b1);
        wr_pos(3, 630, 470, 1'b1);
      end
    endcase
    do_swap("setup_tick");
  endtask

  typedef struct {
    int         setup;
    int         h;
    int         v;
    logic       exp_draw;
    logic [5:0] exp_rgb;
    logic       chk_addr;
    logic [11:0] exp_addr;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] a;
    logic        d;
    logic [5:0]  c;
    int          cur_setup;
    int          draw_cnt;
    int          tick_cnt;

    // Counters are the pixel clock values; each probe's output pixel is (h+3, v) wrapped.
    vecs[0]  = '{0, 97,  50,  1'b1, 6'h0C, 1'b1, 12'h000};
    vecs[1]  = '{0, 96,  50,  1'b0, 6'h00, 1'b0, 12'h000};
    vecs[2]  = '{0, 128, 81,  1'b1, 6'h0C, 1'b1, 12'h3FF};
    vecs[3]  = '{0, 129, 81,  1'b0, 6'h00, 1'b0, 12'h000};
    vecs[4]  = '{0, 107, 49,  1'b0, 6'h00, 1'b0, 12'h000};
    vecs[5]  = '{0, 107, 82,  1'b0, 6'h00, 1'b0, 12'h000};
    vecs[6]  = '{0, 107, 60,  1'b1, 6'h0C, 1'b1, 12'h14A};
    vecs[7]  = '{1, 197, 200, 1'b1, 6'h0C, 1'b1, 12'h000};
    vecs[8]  = '{1, 217, 205, 1'b0, 6'h00, 1'b1, 12'h0B4};
    vecs[9]  = '{1, 212, 231, 1'b1, 6'h0C, 1'b1, 12'h3EF};
    vecs[10] = '{1, 297, 300, 1'b1, 6'h2A, 1'b1, 12'h800};
    vecs[11] = '{1, 329, 331, 1'b0, 6'h00, 1'b0, 12'h000};
    vecs[12] = '{2, 636, 470, 1'b1, 6'h07, 1'b1, 12'hC09};
    vecs[13] = '{2, 637, 470, 1'b0, 6'h00, 1'b0, 12'h000};
    vecs[14] = '{2, 636, 479, 1'b1, 6'h07, 1'b1, 12'hD29};
    vecs[15] = '{2, 636, 480, 1'b0, 6'h00, 1'b0, 12'h000};
    vecs[16] = '{2, 797, 469, 1'b1, 6'h2A, 1'b1, 12'h800};
    vecs[17] = '{2, 797, 468, 1'b0, 6'h00, 1'b0, 12'h000};
    vecs[18] = '{2, 799, 469, 1'b1, 6'h2A, 1'b1, 12'h802};
    vecs[19] = '{2, 798, 524, 1'b0, 6'h00, 1'b0, 12'h000};

    reset      = 1'b1;
    pos_wr_en  = 1'b0;
    pos_wr_idx = 2'd0;
    pos_wr_x   = 10'd0;
    pos_wr_y   = 10'd0;
    pos_wr_vis = 1'b0;
`ifdef SPRITE_HIT_DETECT_EN
    fire  = 1'b0;
    aim_x = 10'd0;
    aim_y = 10'd0;
`endif
    neutral();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_draw", 32'(draw), 32'd0);
    check("reset_rgb", 32'(rgb_out), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_frame_tick", 32'(frame_tick), 32'd0);

    // Compressed empty frame: a few lines including the all-zero sprite corner, one swap.
    draw_cnt = 0;
    tick_cnt = 0;
    for (int line = 0; line < 4; line++) begin
      for (int h = 0; h < 100; h++) begin
        @(negedge clk);
        draw_cnt += int'(draw);
        tick_cnt += int'(frame_tick);
        hor_count = 10'(h);
        ver_count = (line == 3) ? 10'd480 : 10'(line * 160);
      end
    end
    repeat (4) begin
      @(negedge clk);
      draw_cnt += int'(draw);
      tick_cnt += int'(frame_tick);
      neutral();
    end
    $display("empty frame draws=%0d ticks=%0d", draw_cnt, tick_cnt);
    check("empty_draw_count", 32'(draw_cnt), 32'd0);
    check("empty_tick_count", 32'(tick_cnt), 32'd1);

    cur_setup = -1;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].setup != cur_setup) begin
        cur_setup = vecs[i].setup;
        load_setup(cur_setup);
      end
      probe(vecs[i].h, vecs[i].v, a, d, c);
      $display("vec %0d setup=%0d h=%0d v=%0d addr=%03h draw=%0b rgb=%02h",
               i, vecs[i].setup, vecs[i].h, vecs[i].v, a, d, c);
      check($sformatf("vec%0d_draw", i), 32'(d), 32'(vecs[i].exp_draw));
      check($sformatf("vec%0d_rgb", i), 32'(c), 32'(vecs[i].exp_rgb));
      if (vecs[i].chk_addr) begin
        check($sformatf("vec%0d_addr", i), 32'(a), 32'(vecs[i].exp_addr));
      end
    end

    // Reset one cycle after a hitting pixel enters the pipeline: nothing may emerge.
    @(negedge clk);
    hor_count = 10'd797;
    ver_count = 10'd469;
    @(negedge clk);
    neutral();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_flush", 32'(draw), 32'd0);
    do_swap("post_reset_tick");
    probe_draw("post_reset_old_sprite", 797, 469, 1'b0);
    probe_draw("post_reset_origin", 797, 524, 1'b0);

    // Shadow-only writes stay hidden until the swap.
    key_mode = 1'b0;
    wr_pos(0, 100, 50, 1'b1);
    probe_draw("pre_swap_hidden", 97, 50, 1'b0);
    do_swap("swap_a");
    probe_draw("post_swap_shown", 97, 50, 1'b1);

    // Write coincident with the swap lands one frame later.
    @(negedge clk);
    hor_count  = 10'd0;
    ver_count  = 10'd480;
    pos_wr_en  = 1'b1;
    pos_wr_idx = 2'd0;
    pos_wr_x   = 10'd400;
    pos_wr_y   = 10'd300;
    pos_wr_vis = 1'b1;
    @(negedge clk);
    pos_wr_en = 1'b0;
    neutral();
    check("same_cycle_tick", 32'(frame_tick), 32'd1);
    probe_draw("same_cycle_old_kept", 97, 50, 1'b1);
    probe_draw("same_cycle_new_hidden", 397, 300, 1'b0);
    do_swap("swap_b");
    probe_draw("next_frame_old_gone", 97, 50, 1'b0);
    probe_draw("next_frame_new_shown", 397, 300, 1'b1);

`ifdef SPRITE_HIT_DETECT_EN
    // Sprite 2 alone at (100,50); aim at (110,60) then at (5,5).
    wr_pos(0, 0, 0, 1'b0);
    wr_pos(1, 0, 0, 1'b0);
    wr_pos(2, 100, 50, 1'b1);
    wr_pos(3, 0, 0, 1'b0);
    do_swap("det_setup");
    for (int shot = 0; shot < 2; shot++) begin
      @(negedge clk);
      fire  = 1'b1;
      aim_x = (shot == 0) ? 10'd110 : 10'd5;
      aim_y = (shot == 0) ? 10'd60  : 10'd5;
      @(negedge clk);
      fire = 1'b0;
      @(negedge clk);
      hor_count = 10'd0;
      ver_count = 10'd480;
      @(negedge clk);
      neutral();
      check($sformatf("shot%0d_first_tick_quiet", shot), 32'(hit_valid), 32'd0);
      for (int h = 100; h < 121; h++) begin
        @(negedge clk);
        hor_count = 10'(h);
        ver_count = 10'd60;
      end
      @(negedge clk);
      hor_count = 10'd0;
      ver_count = 10'd480;
      @(negedge clk);
      neutral();
      $display("shot %0d hit_valid=%0b hit_idx=%0d hit_miss=%0b", shot, hit_valid, hit_idx, hit_miss);
      check($sformatf("shot%0d_valid", shot), 32'(hit_valid), 32'd1);
      check($sformatf("shot%0d_idx", shot), 32'(hit_idx), (shot == 0) ? 32'd2 : 32'd0);
      check($sformatf("shot%0d_miss", shot), 32'(hit_miss), (shot == 0) ? 32'd0 : 32'd1);
      @(negedge clk);
      check($sformatf("shot%0d_valid_pulse", shot), 32'(hit_valid), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
